sipo_rx: RTL

Serial-in/parallel-out receiver. It is the receive end for the team's PISO serializer. It captures a framed serial bit stream, one bit per strobed clock, into a WIDTH-bit word and presents the word on a one-entry valid/ready output buffer. Typical use is the far end of a PISO link, or feeding a downstream register bank.

---
 rtl/sipo_pkg.sv | 15 +
 rtl/sipo_out_buf.sv | 64 ++++++
 rtl/sipo_rx.sv | 96 +++++++++
 3 files changed

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the sipo_rx serial-in/parallel-out receiver.
// Holds the receiver state encoding and the bit-counter width derivation.
package sipo_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Counter must hold 0..WIDTH, so it needs clog2(WIDTH+1) bits.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// One-word valid/ready holding register for received frames.
// Loads a completed word when empty or draining, otherwise drops it and flags overrun.
module sipo_out_buf
    import sipo_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    input  logic             p_ready,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] p_out,
    output logic             p_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             accept;
    logic             drop;

    always_comb begin
        // A full buffer can still accept if it is being drained on this same edge.
        accept    = load_valid && (!valid_q || p_ready);
        drop      = load_valid && !accept;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (accept) begin
            data_d  = load_data;
            valid_d = 1'b1;
        end else if (valid_q && p_ready) begin
            valid_d = 1'b0;
        end

        // A drop on the same edge as a clear must leave the flag set.
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_ovr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign p_out   = data_q;
    assign p_valid = valid_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: framed bit capture into a WIDTH-bit word,
// presented through a one-entry valid/ready buffer with sticky overrun.
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sin,
    input  logic                          sin_valid,
    input  logic                          start,
    output logic [WIDTH-1:0]              p_out,
    output logic                          p_valid,
    input  logic                          p_ready,
    output logic                          busy,
    output logic [cnt_width(WIDTH)-1:0]   bit_cnt,
    output logic                          overrun,
    input  logic                          clr_ovr
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] first_bit;
    logic             word_done;

    always_comb begin
        // Shift of the running word, and the same shift applied to an empty register
        // for the first bit of a (re)started frame.
        if (MSB_FIRST) begin
            shifted   = {sreg_q[WIDTH-2:0], sin};
            first_bit = {{(WIDTH-1){1'b0}}, sin};
        end else begin
            shifted   = {sin, sreg_q[WIDTH-1:1]};
            first_bit = {sin, {(WIDTH-1){1'b0}}};
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sreg_d    = sreg_q;
        word_done = 1'b0;

        if (start) begin
            // Resync outranks completion: a start always opens a fresh frame.
            state_d   = ST_SHIFT;
            bit_cnt_d = sin_valid ? CNT_W'(1) : '0;
            sreg_d    = sin_valid ? first_bit : '0;
        end else if (state_q == ST_SHIFT && sin_valid) begin
            sreg_d = shifted;
            if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                word_done = 1'b1;
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            sreg_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sreg_q    <= sreg_d;
        end
    end

    sipo_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk        (clk),
        .rst        (rst),
        .load_valid (word_done),
        .load_data  (shifted),
        .p_ready    (p_ready),
        .clr_ovr    (clr_ovr),
        .p_out      (p_out),
        .p_valid    (p_valid),
        .overrun    (overrun)
    );

    assign busy    = (state_q == ST_SHIFT);
    assign bit_cnt = bit_cnt_q;

endmodule
